// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package muldiv_pkg;

    // funct7 that steers an R-type instruction to this unit instead of the ALU
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the muldiv unit.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            i_valid;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_rs1;
    logic [XLEN-1:0] i_rs2;
    logic            i_flush;
    logic            o_ready;
    logic            o_valid;
    logic [XLEN-1:0] o_result;

    modport master (
        output i_valid, i_funct3, i_rs1, i_rs2, i_flush,
        input  o_ready, o_valid, o_result
    );

    modport slave (
        input  i_valid, i_funct3, i_rs1, i_rs2, i_flush,
        output o_ready, o_valid, o_result
    );
endinterface

// File: rtl/muldiv_decode.sv
// funct3 to operation-class flags for the muldiv unit.
module muldiv_decode
    import muldiv_pkg::*;
(
    input  logic [2:0] funct3_i,
    output logic       is_div_o,
    output logic       is_rem_o,
    output logic       high_half_o,
    output logic       rs1_signed_o,
    output logic       rs2_signed_o
);

    // Pure lookup; MUL and the unsigned ops fall through to all-unsigned.
    always_comb begin
        is_div_o     = funct3_i[2];
        is_rem_o     = 1'b0;
        high_half_o  = 1'b0;
        rs1_signed_o = 1'b0;
        rs2_signed_o = 1'b0;
        case (funct3_i)
            F3_MULH: begin
                high_half_o  = 1'b1;
                rs1_signed_o = 1'b1;
                rs2_signed_o = 1'b1;
            end
            F3_MULHSU: begin
                high_half_o  = 1'b1;
                rs1_signed_o = 1'b1;
            end
            F3_MULHU: high_half_o = 1'b1;
            F3_DIV: begin
                rs1_signed_o = 1'b1;
                rs2_signed_o = 1'b1;
            end
            F3_REM: begin
                is_rem_o     = 1'b1;
                rs1_signed_o = 1'b1;
                rs2_signed_o = 1'b1;
            end
            F3_REMU: is_rem_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and
// restoring division on unsigned magnitudes, sign fix-up at completion.
//
// state | meaning
// IDLE  | ready for a new request, o_ready high
// CALC  | one multiplier / quotient bit per cycle, XLEN cycles
// DONE  | o_valid pulse with o_result, back to IDLE next cycle
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic    i_clk,
    input  logic    i_reset,
    muldiv_if.slave bus
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q;       // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]   opa_q;       // mul: multiplicand magnitude; div: divisor magnitude
    logic              is_div_q;
    logic              is_rem_q;
    logic              high_q;
    logic              neg_q;       // product / quotient sign
    logic              rem_neg_q;   // remainder sign follows the dividend
    logic              ready_q;
    logic              valid_q;
    logic [XLEN-1:0]   result_q;

    logic              dec_is_div;
    logic              dec_is_rem;
    logic              dec_high;
    logic              dec_rs1_signed;
    logic              dec_rs2_signed;

    muldiv_decode u_decode (
        .funct3_i     (bus.i_funct3),
        .is_div_o     (dec_is_div),
        .is_rem_o     (dec_is_rem),
        .high_half_o  (dec_high),
        .rs1_signed_o (dec_rs1_signed),
        .rs2_signed_o (dec_rs2_signed)
    );

    logic            rs1_neg;
    logic            rs2_neg;
    logic [XLEN-1:0] rs1_mag;
    logic [XLEN-1:0] rs2_mag;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_res;

    // Operand conditioning and division special cases, evaluated at accept.
    always_comb begin
        rs1_neg     = dec_rs1_signed & bus.i_rs1[XLEN-1];
        rs2_neg     = dec_rs2_signed & bus.i_rs2[XLEN-1];
        rs1_mag     = rs1_neg ? -bus.i_rs1 : bus.i_rs1;
        rs2_mag     = rs2_neg ? -bus.i_rs2 : bus.i_rs2;
        div_zero    = dec_is_div && (bus.i_rs2 == '0);
        div_ovf     = dec_is_div && dec_rs1_signed && (bus.i_rs1 == MIN_NEG) && (bus.i_rs2 == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = dec_is_rem ? bus.i_rs1 : '1;
        end else if (div_ovf) begin
            special_res = dec_is_rem ? '0 : bus.i_rs1;
        end
    end

    logic [XLEN:0]     mul_sum;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] acc_d;
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   result_d;

    // One iteration step and the signed result of the final step.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : '0);
        // The true difference is below 2^XLEN whenever div_ge holds, so the
        // top remainder bit can be dropped before subtracting.
        div_ge   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} >= {1'b0, opa_q};
        div_diff = {acc_q[2*XLEN-2:XLEN], acc_q[XLEN-1]} - opa_q;
        if (is_div_q) begin
            acc_d = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1} : {acc_q[2*XLEN-2:0], 1'b0};
        end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end

        prod_signed = neg_q ? -acc_d : acc_d;
        quo         = neg_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
        rem         = rem_neg_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
        if (is_div_q) begin
            result_d = is_rem_q ? rem : quo;
        end else begin
            result_d = high_q ? prod_signed[2*XLEN-1:XLEN] : prod_signed[XLEN-1:0];
        end
    end

    // Control FSM and datapath registers; all outputs come straight from flops.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opa_q     <= '0;
            is_div_q  <= 1'b0;
            is_rem_q  <= 1'b0;
            high_q    <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.i_valid && !bus.i_flush) begin
                        is_div_q  <= dec_is_div;
                        is_rem_q  <= dec_is_rem;
                        high_q    <= dec_high;
                        neg_q     <= rs1_neg ^ rs2_neg;
                        rem_neg_q <= rs1_neg;
                        acc_q     <= {{XLEN{1'b0}}, (dec_is_div ? rs1_mag : rs2_mag)};
                        opa_q     <= dec_is_div ? rs2_mag : rs1_mag;
                        cnt_q     <= '0;
                        ready_q   <= 1'b0;
                        if (div_zero || div_ovf) begin
                            state_q  <= DONE;
                            valid_q  <= 1'b1;
                            result_q <= special_res;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.i_flush) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(XLEN - 1)) begin
                            state_q  <= DONE;
                            valid_q  <= 1'b1;
                            result_q <= result_d;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_ready  = ready_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_result = result_q;

endmodule
